// File: rtl/rf_wb_arbiter_if.sv
// Write-back bus between the two requesters, the arbiter and the register file write port.
// The slave modport is the arbiter's view of the bus; master is the view of the agents driving it.
interface rf_wb_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          wb_en;
    logic          req0_valid;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_data;
    logic          req0_ready;
    logic          req1_valid;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_data;
    logic          req1_ready;
    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;
    logic          grant_id;
    logic [15:0]   stall_cnt;

    modport slave (
        input  wb_en,
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        output rf_we, rf_wa, rf_wd, grant_id, stall_cnt
    );

    modport master (
        output wb_en,
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        input  rf_we, rf_wa, rf_wd, grant_id, stall_cnt
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter for the register file's single write port. It drops writes to
// register 0 and keeps a saturating count of cycles in which a valid requester was refused.
module rf_wb_arbiter #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input logic            clk,
    input logic            rst,
    rf_wb_arbiter_if.slave bus
);
    logic          last;
    logic          ready0;
    logic          ready1;
    logic          handshake;
    logic          sel;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;
    logic          stall;

    logic          rf_we_q;
    logic [AW-1:0] rf_wa_q;
    logic [DW-1:0] rf_wd_q;
    logic          grant_id_q;
    logic [15:0]   stall_cnt_q;

    // Under contention the port that did not win last time gets the grant
    always_comb begin
        ready0    = 1'b0;
        ready1    = 1'b0;
        handshake = 1'b0;
        sel       = 1'b0;
        sel_addr  = '0;
        sel_data  = '0;
        stall     = 1'b0;

        if (bus.wb_en) begin
            ready0 = bus.req0_valid & (~bus.req1_valid | last);
            ready1 = bus.req1_valid & (~bus.req0_valid | ~last);
        end

        handshake = ready0 | ready1;
        sel       = ready1;
        sel_addr  = ready1 ? bus.req1_addr : bus.req0_addr;
        sel_data  = ready1 ? bus.req1_data : bus.req0_data;
        stall     = (bus.req0_valid & ~ready0) | (bus.req1_valid & ~ready1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last        <= 1'b1;
            rf_we_q     <= 1'b0;
            rf_wa_q     <= '0;
            rf_wd_q     <= '0;
            grant_id_q  <= 1'b0;
            stall_cnt_q <= 16'h0000;
        end else begin
            rf_we_q <= 1'b0;
            if (handshake) begin
                last       <= sel;
                rf_we_q    <= (sel_addr != '0);
                rf_wa_q    <= sel_addr;
                rf_wd_q    <= sel_data;
                grant_id_q <= sel;
            end
            if (stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.rf_we      = rf_we_q;
    assign bus.rf_wa      = rf_wa_q;
    assign bus.rf_wd      = rf_wd_q;
    assign bus.grant_id   = grant_id_q;
    assign bus.stall_cnt  = stall_cnt_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: a per-cycle vector table followed by hand-written
// sequences for asynchronous reset and stall counter saturation.
module tb_rf_wb_arbiter;
    typedef struct {
        logic        wb_en;
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        r0;
        logic        r1;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        gid;
        logic [15:0] stall;
    } vec_t;

    localparam int NVEC = 14;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs [NVEC];

    rf_wb_arbiter_if #(.DW(32), .AW(5)) bus ();

    rf_wb_arbiter #(.DW(32), .AW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic wb_en, input logic v0, input logic [4:0] a0,
                                  input logic [31:0] d0, input logic v1, input logic [4:0] a1,
                                  input logic [31:0] d1);
        bus.wb_en      = wb_en;
        bus.req0_valid = v0;
        bus.req0_addr  = a0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_addr  = a1;
        bus.req1_data  = d1;
    endtask

    task automatic check_regs(input string tag, input logic we, input logic [4:0] wa,
                              input logic [31:0] wd, input logic gid, input logic [15:0] stall);
        check_output({tag, "_rf_we"}, 32'(bus.rf_we), 32'(we));
        check_output({tag, "_rf_wa"}, 32'(bus.rf_wa), 32'(wa));
        check_output({tag, "_rf_wd"}, bus.rf_wd, wd);
        check_output({tag, "_grant_id"}, 32'(bus.grant_id), 32'(gid));
        check_output({tag, "_stall_cnt"}, 32'(bus.stall_cnt), 32'(stall));
    endtask

    task automatic do_reset();
        apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;

        //           wb    v0    a0     d0             v1    a1     d1          r0    r1    we    wa     wd             gid   stall
        vecs[0]  = '{1'b1, 1'b1, 5'd1,  32'h11,       1'b1, 5'd5,  32'h55,     1'b1, 1'b0, 1'b1, 5'd1,  32'h11,       1'b0, 16'd1};
        vecs[1]  = '{1'b1, 1'b1, 5'd2,  32'h22,       1'b1, 5'd5,  32'h55,     1'b0, 1'b1, 1'b1, 5'd5,  32'h55,       1'b1, 16'd2};
        vecs[2]  = '{1'b1, 1'b1, 5'd2,  32'h22,       1'b1, 5'd6,  32'h66,     1'b1, 1'b0, 1'b1, 5'd2,  32'h22,       1'b0, 16'd3};
        vecs[3]  = '{1'b1, 1'b1, 5'd3,  32'h33,       1'b1, 5'd6,  32'h66,     1'b0, 1'b1, 1'b1, 5'd6,  32'h66,       1'b1, 16'd4};
        vecs[4]  = '{1'b1, 1'b1, 5'd3,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,      1'b1, 1'b0, 1'b1, 5'd3,  32'hDEADBEEF, 1'b0, 16'd4};
        vecs[5]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,      1'b0, 1'b0, 1'b0, 5'd3,  32'hDEADBEEF, 1'b0, 16'd4};
        vecs[6]  = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h1234,   1'b0, 1'b1, 1'b0, 5'd0,  32'h1234,     1'b1, 16'd4};
        vecs[7]  = '{1'b1, 1'b1, 5'd9,  32'h99,       1'b1, 5'd10, 32'hAA,     1'b1, 1'b0, 1'b1, 5'd9,  32'h99,       1'b0, 16'd5};
        vecs[8]  = '{1'b0, 1'b1, 5'd12, 32'hCC,       1'b0, 5'd0,  32'h0,      1'b0, 1'b0, 1'b0, 5'd9,  32'h99,       1'b0, 16'd6};
        vecs[9]  = '{1'b0, 1'b1, 5'd12, 32'hCC,       1'b0, 5'd0,  32'h0,      1'b0, 1'b0, 1'b0, 5'd9,  32'h99,       1'b0, 16'd7};
        vecs[10] = '{1'b0, 1'b1, 5'd12, 32'hCC,       1'b0, 5'd0,  32'h0,      1'b0, 1'b0, 1'b0, 5'd9,  32'h99,       1'b0, 16'd8};
        vecs[11] = '{1'b1, 1'b1, 5'd12, 32'hCC,       1'b0, 5'd0,  32'h0,      1'b1, 1'b0, 1'b1, 5'd12, 32'hCC,       1'b0, 16'd8};
        vecs[12] = '{1'b0, 1'b1, 5'd1,  32'h1,        1'b1, 5'd2,  32'h2,      1'b0, 1'b0, 1'b0, 5'd12, 32'hCC,       1'b0, 16'd9};
        vecs[13] = '{1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,      1'b0, 1'b0, 1'b0, 5'd12, 32'hCC,       1'b0, 16'd9};

        do_reset();
        #1;
        check_output("reset_req0_ready", 32'(bus.req0_ready), 32'd0);
        check_output("reset_req1_ready", 32'(bus.req1_ready), 32'd0);
        check_regs("reset", 1'b0, 5'd0, 32'h0, 1'b0, 16'd0);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            apply_stimulus(vecs[i].wb_en, vecs[i].v0, vecs[i].a0, vecs[i].d0,
                           vecs[i].v1, vecs[i].a1, vecs[i].d1);
            #1;
            check_output($sformatf("vec%0d_req0_ready", i), 32'(bus.req0_ready), 32'(vecs[i].r0));
            check_output($sformatf("vec%0d_req1_ready", i), 32'(bus.req1_ready), 32'(vecs[i].r1));
            @(posedge clk);
            #1;
            check_regs($sformatf("vec%0d", i), vecs[i].we, vecs[i].wa, vecs[i].wd,
                       vecs[i].gid, vecs[i].stall);
        end

        // Reset lands while an accepted write to r7 sits on rf_*, before the register file commits it
        @(negedge clk);
        apply_stimulus(1'b1, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        apply_stimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check_output("pre_rst_rf_we", 32'(bus.rf_we), 32'd1);
        check_output("pre_rst_rf_wa", 32'(bus.rf_wa), 32'd7);
        #2;
        rst = 1'b1;
        #1;
        check_regs("async_rst", 1'b0, 5'd0, 32'h0, 1'b0, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        apply_stimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h44);
        #1;
        check_output("post_rst_req1_ready", 32'(bus.req1_ready), 32'd1);
        @(posedge clk);
        #1;
        check_regs("post_rst", 1'b1, 5'd4, 32'h44, 1'b1, 16'd0);

        // After reset the pointer favours port 0 on the first contention
        do_reset();
        apply_stimulus(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
        #1;
        check_output("first_contention_req0_ready", 32'(bus.req0_ready), 32'd1);
        check_output("first_contention_req1_ready", 32'(bus.req1_ready), 32'd0);

        for (int k = 1; k <= 65540; k++) begin
            @(posedge clk);
            #1;
            if (k == 65534) check_output("stall_cnt_below_sat", 32'(bus.stall_cnt), 32'hFFFE);
            if (k == 65535) check_output("stall_cnt_at_sat", 32'(bus.stall_cnt), 32'hFFFF);
        end
        check_output("stall_cnt_held_sat", 32'(bus.stall_cnt), 32'hFFFF);
        check_output("sat_last_grant", 32'(bus.grant_id), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
